// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B single-wire LED encoder and decoder.
// Holds the state encoding, the pixel width and the 64 MHz default timings.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StLatch
  } state_e;

  localparam int unsigned BITS_PER_PIXEL   = 24;

  localparam int unsigned DEF_T0H_CYCLES   = 26;
  localparam int unsigned DEF_T1H_CYCLES   = 51;
  localparam int unsigned DEF_BIT_CYCLES   = 80;
  localparam int unsigned DEF_LATCH_CYCLES = 3200;

  // High-time split point for the receive decoder: below is a 0, above is a 1.
  localparam int unsigned DEC_T1_THRESHOLD = 38;

  function automatic int unsigned eff_bit(input int unsigned bit_cycles);
    return (bit_cycles < 2) ? 2 : bit_cycles;
  endfunction

  // Keep at least one high and one low cycle inside every bit.
  function automatic int unsigned eff_high(input int unsigned th, input int unsigned bit_eff);
    if (th < 1) begin
      return 1;
    end
    if (th > bit_eff - 1) begin
      return bit_eff - 1;
    end
    return th;
  endfunction

endpackage

// File: rtl/ws2812b_bit_timer.sv
// Times one NRZ bit: a high phase of th_eff cycles then a low phase filling the bit period.
// Both lengths are captured on the start strobe and held for the whole bit.
module ws2812b_bit_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_th_eff,
  input  logic [CNT_W-1:0] i_bit_eff,
  output logic             o_high_phase,
  output logic             o_high_end,
  output logic             o_bit_end
);

  logic             r_run;
  logic             r_high;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_th;
  logic [CNT_W-1:0] r_tl;
  logic             w_high_end;
  logic             w_bit_end;

  assign w_high_end = r_run && r_high && (r_cnt == r_th - CNT_W'(1));
  assign w_bit_end  = r_run && !r_high && (r_cnt == r_tl - CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run  <= 1'b0;
      r_high <= 1'b0;
      r_cnt  <= '0;
      r_th   <= '0;
      r_tl   <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_high <= 1'b1;
      r_cnt  <= '0;
      r_th   <= i_th_eff;
      r_tl   <= i_bit_eff - i_th_eff;
    end else if (r_run) begin
      if (r_high) begin
        if (w_high_end) begin
          r_high <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_bit_end) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_high_phase = r_run && r_high;
    o_high_end   = w_high_end;
    o_bit_end    = w_bit_end;
  end

endmodule

// File: rtl/ws2812b_pulse_encoder.sv
// WS2812B transmit serializer: one-word holding buffer, MSB-first shift register and a
// latch (reset) low period appended whenever the buffer runs dry at the end of a pixel.
module ws2812b_pulse_encoder
  import ws2812b_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned BITS_PER_PIXEL = ws2812b_pkg::BITS_PER_PIXEL
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [BITS_PER_PIXEL-1:0] i_pixel_data,
  input  logic                      i_pixel_valid,
  output logic                      o_pixel_ready,
  input  logic [CNT_W-1:0]          i_t0h_cycles,
  input  logic [CNT_W-1:0]          i_t1h_cycles,
  input  logic [CNT_W-1:0]          i_bit_cycles,
  input  logic [CNT_W-1:0]          i_latch_cycles,
  output logic                      o_dout,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  localparam int unsigned IDX_W = $clog2(BITS_PER_PIXEL);

  state_e                    r_state;
  state_e                    w_state_d;
  logic [BITS_PER_PIXEL-1:0] r_buf;
  logic                      r_buf_valid;
  logic                      w_buf_valid_d;
  logic [BITS_PER_PIXEL-1:0] r_shift;
  logic [BITS_PER_PIXEL-1:0] w_shift_d;
  logic [IDX_W-1:0]          r_bit_idx;
  logic [IDX_W-1:0]          w_bit_idx_d;
  logic [CNT_W-1:0]          r_latch_cnt;
  logic [CNT_W-1:0]          w_latch_cnt_d;
  logic [CNT_W-1:0]          r_latch_len;
  logic [CNT_W-1:0]          w_latch_len_d;
  logic                      r_dout;
  logic                      w_dout_d;
  logic                      r_frame_done;
  logic                      w_frame_done_d;

  logic                      w_handshake;
  logic                      w_load;
  logic                      w_start;
  logic                      w_next_msb;
  logic                      w_latch_last;
  logic [CNT_W-1:0]          w_bit_eff;
  logic [CNT_W-1:0]          w_th;
  logic [CNT_W-1:0]          w_th_eff;
  logic                      w_high_phase;
  logic                      w_high_end;
  logic                      w_bit_end;

  assign w_handshake  = i_pixel_valid && !r_buf_valid;
  assign w_latch_last = (r_latch_cnt == r_latch_len - CNT_W'(1));

  // Timing is evaluated for the bit about to start; w_next_msb selects which high time applies.
  assign w_bit_eff = CNT_W'(eff_bit(32'(i_bit_cycles)));
  assign w_th      = w_next_msb ? i_t1h_cycles : i_t0h_cycles;
  assign w_th_eff  = CNT_W'(eff_high(32'(w_th), 32'(w_bit_eff)));

  ws2812b_bit_timer #(
    .CNT_W (CNT_W)
  ) u_bit_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (w_start),
    .i_th_eff     (w_th_eff),
    .i_bit_eff    (w_bit_eff),
    .o_high_phase (w_high_phase),
    .o_high_end   (w_high_end),
    .o_bit_end    (w_bit_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_load        = 1'b0;
    w_start       = 1'b0;
    w_next_msb    = r_buf[BITS_PER_PIXEL-1];
    w_shift_d     = r_shift;
    w_bit_idx_d   = r_bit_idx;
    w_latch_cnt_d = r_latch_cnt;
    w_latch_len_d = r_latch_len;
    unique case (r_state)
      StIdle: begin
        if (r_buf_valid) begin
          w_load      = 1'b1;
          w_start     = 1'b1;
          w_shift_d   = r_buf;
          w_bit_idx_d = IDX_W'(BITS_PER_PIXEL - 1);
          w_state_d   = StHigh;
        end
      end
      StHigh: begin
        if (w_high_end) begin
          w_state_d = StLow;
        end
      end
      StLow: begin
        if (w_bit_end) begin
          if (r_bit_idx != '0) begin
            w_start     = 1'b1;
            w_next_msb  = r_shift[BITS_PER_PIXEL-2];
            w_shift_d   = r_shift << 1;
            w_bit_idx_d = r_bit_idx - IDX_W'(1);
            w_state_d   = StHigh;
          end else if (r_buf_valid) begin
            w_load      = 1'b1;
            w_start     = 1'b1;
            w_shift_d   = r_buf;
            w_bit_idx_d = IDX_W'(BITS_PER_PIXEL - 1);
            w_state_d   = StHigh;
          end else begin
            w_latch_cnt_d = '0;
            w_latch_len_d = (i_latch_cycles == '0) ? CNT_W'(1) : i_latch_cycles;
            w_state_d     = StLatch;
          end
        end
      end
      StLatch: begin
        if (w_latch_last) begin
          w_latch_cnt_d = '0;
          w_state_d     = StIdle;
        end else begin
          w_latch_cnt_d = r_latch_cnt + CNT_W'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Handshake and load are mutually exclusive: one needs the buffer empty, the other full.
  always_comb begin
    w_buf_valid_d = r_buf_valid;
    if (w_load) begin
      w_buf_valid_d = 1'b0;
    end
    if (w_handshake) begin
      w_buf_valid_d = 1'b1;
    end
    w_dout_d       = w_high_phase;
    w_frame_done_d = (r_state == StLatch) && w_latch_last;
    o_pixel_ready  = !r_buf_valid;
    o_busy         = (r_state != StIdle) || r_buf_valid;
    o_dout         = r_dout;
    o_frame_done   = r_frame_done;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf        <= '0;
      r_buf_valid  <= 1'b0;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_latch_cnt  <= '0;
      r_latch_len  <= '0;
      r_dout       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_buf <= i_pixel_data;
      end
      r_buf_valid  <= w_buf_valid_d;
      r_shift      <= w_shift_d;
      r_bit_idx    <= w_bit_idx_d;
      r_latch_cnt  <= w_latch_cnt_d;
      r_latch_len  <= w_latch_len_d;
      r_dout       <= w_dout_d;
      r_frame_done <= w_frame_done_d;
    end
  end

endmodule

// File: tb/tb_ws2812b_pulse_encoder.sv
// Bench for the WS2812B encoder: expected pulse widths are queued when a pixel is offered
// and compared against measured dout high/low run lengths.
module tb_ws2812b_pulse_encoder;

  logic        clk;
  logic        rst_n;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [15:0] t0h;
  logic [15:0] t1h;
  logic [15:0] bitc;
  logic [15:0] latch;
  logic        dout;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int frames   = 0;
  bit mon_en   = 1'b1;

  typedef struct {
    int h;
    int l;
    bit last;
  } pulse_t;

  pulse_t exp_q[$];

  ws2812b_pulse_encoder #(
    .CNT_W          (16),
    .BITS_PER_PIXEL (24)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pixel_data   (pixel_data),
    .i_pixel_valid  (pixel_valid),
    .o_pixel_ready  (pixel_ready),
    .i_t0h_cycles   (t0h),
    .i_t1h_cycles   (t1h),
    .i_bit_cycles   (bitc),
    .i_latch_cycles (latch),
    .o_dout         (dout),
    .o_busy         (busy),
    .o_frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: measures dout run lengths on the falling clock edge and pops the scoreboard.
  initial begin : monitor
    bit     prev;
    int     run;
    bit     pending;
    bit     p_last;
    int     p_low;
    pulse_t e;
    bit     exp_busy;
    prev = 0; run = 0; pending = 0; p_last = 0; p_low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev = 0; run = 0; pending = 0;
      end else begin
        if (dout == prev) begin
          run++;
        end else begin
          if (prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              $display("FAIL unexpected_pulse: high run %0d, no pulse expected", run);
            end else begin
              e = exp_q.pop_front();
              if (run !== e.h) begin
                $display("FAIL high_width: got %0d cycles, expected %0d", run, e.h);
              end else begin
                n_pass++;
              end
              pending = 1; p_low = e.l; p_last = e.last;
            end
          end else begin
            if (pending && !p_last) begin
              n_checks++;
              if (run !== p_low) begin
                $display("FAIL low_width: got %0d cycles, expected %0d", run, p_low);
              end else begin
                n_pass++;
              end
            end
            pending = 0;
          end
          run = 1;
          prev = dout;
        end
        if (frame_done) begin
          frames++;
          exp_busy = (exp_q.size() != 0);
          n_checks++;
          if (!(pending && p_last) || run !== p_low || dout !== 1'b0 || busy !== exp_busy) begin
            $display("FAIL frame_end: pend_last=%0b low_run=%0d exp=%0d busy=%0b exp_busy=%0b",
                     pending && p_last, run, p_low, busy, exp_busy);
          end else begin
            n_pass++;
          end
          pending = 0;
        end
      end
    end
  end

  task automatic push_bit(input int h, input int l, input bit last);
    pulse_t e;
    e.h = h; e.l = l; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_pixel(input logic [23:0] d, input bit last);
    int be;
    int th;
    int le;
    be = (int'(bitc) < 2) ? 2 : int'(bitc);
    le = (latch == 16'd0) ? 1 : int'(latch);
    for (int i = 23; i >= 0; i--) begin
      th = d[i] ? int'(t1h) : int'(t0h);
      if (th < 1) th = 1;
      if (th > be - 1) th = be - 1;
      if (last && i == 0) push_bit(th, be - th + le, 1'b1);
      else                push_bit(th, be - th, 1'b0);
    end
  endtask

  task automatic send_pixel(input logic [23:0] d, input int limit, output int waited);
    pixel_data  = d;
    pixel_valid = 1'b1;
    waited = 0;
    while (!pixel_ready && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (!pixel_ready) begin
      n_checks++;
      $display("FAIL send_timeout: pixel_ready still %0b after %0d cycles", pixel_ready, waited);
      pixel_valid = 1'b0;
    end else begin
      @(negedge clk);
      pixel_valid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target, input int limit);
    int cnt;
    cnt = 0;
    while (frames < target && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (frames < target) $display("FAIL frame_timeout: frames %0d, required %0d", frames, target);
    else n_pass++;
  endtask

  task automatic set_defaults();
    t0h = 16'd26; t1h = 16'd51; bitc = 16'd80; latch = 16'd3200;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pixel_valid = 1'b0;
    pixel_data = '0;
    set_defaults();
    repeat (3) @(negedge clk);
    n_checks++;
    if (dout !== 1'b0 || pixel_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL reset_in: dout=%0b ready=%0b busy=%0b fd=%0b, want 0 1 0 0",
               dout, pixel_ready, busy, frame_done);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dout !== 1'b0 || pixel_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL reset_out: dout=%0b ready=%0b busy=%0b fd=%0b, want 0 1 0 0",
               dout, pixel_ready, busy, frame_done);
    else n_pass++;
  endtask

  task automatic test_single();
    int f0;
    int w;
    f0 = frames;
    set_defaults();
    push_pixel(24'hFF0000, 1'b1);
    send_pixel(24'hFF0000, 10, w);
    @(negedge clk);
    n_checks++;
    if (dout !== 1'b0) $display("FAIL idle_lat_n1: dout=%0b, want 0", dout);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dout !== 1'b1) $display("FAIL idle_lat_n2: dout=%0b, want 1", dout);
    else n_pass++;
    wait_frames(f0 + 1, 6000);
    repeat (20) @(negedge clk);
    n_checks++;
    if (frames !== f0 + 1 || exp_q.size() !== 0 || busy !== 1'b0)
      $display("FAIL single_end: frames=%0d want %0d, queue=%0d, busy=%0b",
               frames - f0, 1, exp_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int f0;
    int w;
    int cnt;
    f0 = frames;
    set_defaults();
    push_pixel(24'hAAAAAA, 1'b0);
    send_pixel(24'hAAAAAA, 10, w);
    push_pixel(24'h555555, 1'b1);
    send_pixel(24'h555555, 200, w);
    n_checks++;
    if (w !== 1) $display("FAIL b2b_accept: waited %0d cycles, want 1", w);
    else n_pass++;
    cnt = 0;
    while (!pixel_ready && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt !== 24 * 80 - 1) $display("FAIL b2b_ready_low: %0d cycles, want %0d", cnt, 24 * 80 - 1);
    else n_pass++;
    wait_frames(f0 + 1, 6000);
    repeat (20) @(negedge clk);
    n_checks++;
    if (frames !== f0 + 1 || exp_q.size() !== 0)
      $display("FAIL b2b_frames: frames=%0d want 1, queue=%0d", frames - f0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_clamp();
    int f0;
    int w;
    f0 = frames;
    t1h = 16'h00FF; t0h = 16'd0; bitc = 16'd10; latch = 16'd20;
    push_pixel(24'h800000, 1'b1);
    send_pixel(24'h800000, 10, w);
    wait_frames(f0 + 1, 1000);
    bitc = 16'd1; latch = 16'd0;
    push_pixel(24'h800000, 1'b1);
    send_pixel(24'h800000, 10, w);
    wait_frames(f0 + 2, 1000);
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL clamp_queue: %0d pulses left, want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_latch_offer();
    int f0;
    int w;
    int cnt;
    f0 = frames;
    set_defaults();
    push_pixel(24'h00FF00, 1'b1);
    send_pixel(24'h00FF00, 10, w);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    repeat (54 + 100) @(negedge clk);
    n_checks++;
    if (pixel_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL latch_ready: ready=%0b busy=%0b, want 1 1", pixel_ready, busy);
    else n_pass++;
    push_pixel(24'h0F0F0F, 1'b1);
    send_pixel(24'h0F0F0F, 0, w);
    cnt = 0;
    while (!frame_done && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (!frame_done || cnt < 3000)
      $display("FAIL latch_len: frame_done=%0b after %0d cycles, want 1 after >=3000", frame_done, cnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dout !== 1'b0) $display("FAIL latch_start_n1: dout=%0b, want 0", dout);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dout !== 1'b1) $display("FAIL latch_start_n2: dout=%0b, want 1", dout);
    else n_pass++;
    wait_frames(f0 + 2, 6000);
  endtask

  task automatic test_reset_mid();
    int w;
    int cnt;
    int highs;
    mon_en = 1'b0;
    set_defaults();
    send_pixel(24'hFFFFFF, 10, w);
    send_pixel(24'h123456, 10, w);
    cnt = 0;
    while (!dout && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dout !== 1'b0) $display("FAIL async_reset: dout=%0b, want 0", dout);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pixel_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL post_reset: ready=%0b busy=%0b, want 1 0", pixel_ready, busy);
    else n_pass++;
    highs = 0;
    repeat (300) begin
      @(negedge clk);
      if (dout) highs++;
    end
    n_checks++;
    if (highs !== 0) $display("FAIL reset_discard: %0d high cycles, want 0", highs);
    else n_pass++;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_midbit_timing();
    int f0;
    int w;
    f0 = frames;
    set_defaults();
    latch = 16'd50;
    push_bit(26, 54, 1'b0);
    for (int i = 0; i < 22; i++) push_bit(26, 74, 1'b0);
    push_bit(26, 74 + 50, 1'b1);
    send_pixel(24'h000000, 10, w);
    repeat (10) @(negedge clk);
    bitc = 16'd100;
    wait_frames(f0 + 1, 4000);
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL midbit_queue: %0d pulses left, want 0", exp_q.size());
    else n_pass++;
    set_defaults();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clamp();
    test_latch_offer();
    test_reset_mid();
    test_midbit_timing();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ws2812b_pulse_encoder.md
Name: ws2812b_pulse_encoder

Overview:
- Transmit-side WS2812B serializer. Peripheral-side sibling of the receive pulse decoder.
- Accepts 24-bit GRB pixel words over a valid/ready handshake and drives the single-wire NRZ pulse stream.
- Bit timing and latch/reset timing are set by run-time cycle-count inputs, so register-programmable timing follows the system clock.
- Has a one-word holding buffer so consecutive pixels go out back-to-back with no gap. Appends a latch (reset) low period when the buffer runs dry.

Parameters:
- CNT_W, 16, width of all timing inputs and of the phase counter.
- BITS_PER_PIXEL, 24, bits per pixel word, shifted MSB first.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- pixel_data  in  24  GRB word; bit 23 is transmitted first.
- pixel_valid  in  1  pixel_data is valid.
- pixel_ready  out  1  holding buffer empty; transfer when pixel_valid && pixel_ready at the clk edge.
- t0h_cycles  in  CNT_W  high time of a 0 bit, in clk cycles.
- t1h_cycles  in  CNT_W  high time of a 1 bit, in clk cycles.
- bit_cycles  in  CNT_W  total bit period, in clk cycles.
- latch_cycles  in  CNT_W  low time appended after the last buffered pixel.
- dout  out  1  registered serial output to the LED chain.
- busy  out  1  state != IDLE or buffer occupied.
- frame_done  out  1  one-cycle pulse when the latch period completes.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, dout=0, pixel_ready=1, busy=0, frame_done=0, buffer empty, counters 0.
- Reset asserted mid-bit drives dout low immediately; any buffered pixel is discarded.
- Holding buffer:
  - pixel_ready = !buf_valid.
  - On handshake, buf_valid=1 next cycle.
  - Buffer is freed on the cycle the serializer loads it into the shift register.
- States: IDLE, HIGH, LOW, LATCH.
- IDLE:
  - dout=0.
  - If buf_valid: load shift register, bit_idx=23, latch effective timing, go to HIGH.
  - From an idle handshake at edge N, dout first reads 1 after edge N+2.
- Effective timing, sampled once at the start of each bit and held for that bit:
  - bit_eff = max(bit_cycles, 2).
  - th = shift[23] ? t1h_cycles : t0h_cycles.
  - th_eff = clamp(th, 1, bit_eff-1). At least one high and one low cycle always.
- HIGH: dout=1 for exactly th_eff cycles; then LOW.
- LOW: dout=0 for bit_eff - th_eff cycles. Each bit is exactly bit_eff cycles.
- End of LOW:
  - If bit_idx>0: shift left, decrement bit_idx, back to HIGH.
  - If bit_idx==0 and buf_valid: load the new pixel and go straight to HIGH, no gap cycles.
  - Otherwise go to LATCH.
- LATCH:
  - dout=0 for max(latch_cycles,1) cycles.
  - A pixel accepted during LATCH is held; the latch is not shortened.
  - At completion: frame_done=1 for one cycle, go to IDLE. If buf_valid, transmission starts per IDLE rules.
- Phase counter is CNT_W bits and counts up from 0, reset at each phase change; no wrap is possible given the clamps.
- Timing input changes mid-bit have no effect until the next bit start.
- pixel_valid while pixel_ready=0 is ignored. The source holds data per the handshake.
- busy covers the whole latch period and the buffered-but-not-started case.

Decomposition:
- Shared package ws2812b_pkg:
  - state encoding (IDLE/HIGH/LOW/LATCH).
  - BITS_PER_PIXEL.
  - default timing constants for a 64 MHz clk: T0H=26, T1H=51, BIT=80, LATCH=3200.
  - A later decoder threshold constant (≈38) lives here too.
- One natural sub-module: ws2812b_bit_timer.
  - Inputs: start strobe, th_eff, bit_eff.
  - Outputs: high_phase, bit_end.
  - The top level keeps the buffer, shift register, bit index and latch logic.

Test Plan:
- Single pixel 0xFF0000, T0H=26, T1H=51, BIT=80, LATCH=3200 -> 8 pulses of 51 high/29 low, then 16 pulses of 26/54; then dout low 3200 cycles; frame_done pulses once; busy falls with it.
- Back-to-back pixels 0xAAAAAA then 0x555555, second offered during first -> 48 contiguous 80-cycle bits with no gap; pixel_ready low from second accept until first pixel's bit 0 ends; one frame_done only.
- Clamp cases t1h_cycles=0x00FF, bit_cycles=10, pixel 0x800000 -> first bit 9 high/1 low. With t0h_cycles=0, 0-bits are 1 high/9 low. With bit_cycles=1, bit_eff is 2.
- Pixel offered 100 cycles into LATCH -> accepted at once (pixel_ready=1); the full 3200-cycle latch still elapses; frame_done pulses; then transmission starts per IDLE latency.
- rst_n pulled low during a HIGH phase with a pixel buffered -> dout=0 same cycle (async); after release pixel_ready=1, busy=0, no output until a new handshake.
- Timing inputs changed mid-bit (BIT 80->100) -> current bit stays 80 cycles; next bit is 100.
